// File: rtl/ps2_kbd_pkg.sv
// Shared definitions for the PS/2 scan-code (set 2) key event decoder.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package ps2_kbd_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXT     = 3'd1,
    BRK     = 3'd2,
    EXT_BRK = 3'd3,
    SKIP    = 3'd4
  } ps2_state_e;

  // Prefix bytes
  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_E1 = 8'hE1;
  localparam logic [7:0] SC_F0 = 8'hF0;

  // Modifier / special keys (base code; right ctrl is E0-prefixed SC_CTRL)
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  // Keyboard-to-host status bytes that never form part of a key event
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_OVF0   = 8'h00;
  localparam logic [7:0] SC_OVF1   = 8'hFF;

  function automatic logic is_ignored(input logic [7:0] b);
    return (b == SC_BAT_OK) || (b == SC_ACK) || (b == SC_ECHO) ||
           (b == SC_RESEND) || (b == SC_OVF0) || (b == SC_OVF1);
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == SC_E0) || (b == SC_E1) || (b == SC_F0);
  endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// Scan-code set 2 to ASCII map for letters, digits, space, enter, punctuation.
// Latency: combinational.
// Backpressure: n/a.
// Ports: code - base scan code; upper - letters upper case; shift - shifted
//        symbols for digits/punctuation; ascii - 00 when the code is unmapped.
module ps2_ascii_lut (
  input  logic [7:0] code,
  input  logic       upper,
  input  logic       shift,
  output logic [7:0] ascii
);

  logic [7:0] letter;
  logic [7:0] plain;
  logic [7:0] shifted;

  always_comb begin
    letter  = 8'h00;
    plain   = 8'h00;
    shifted = 8'h00;
    case (code)
      8'h1C: letter = "A";  8'h32: letter = "B";  8'h21: letter = "C";
      8'h23: letter = "D";  8'h24: letter = "E";  8'h2B: letter = "F";
      8'h34: letter = "G";  8'h33: letter = "H";  8'h43: letter = "I";
      8'h3B: letter = "J";  8'h42: letter = "K";  8'h4B: letter = "L";
      8'h3A: letter = "M";  8'h31: letter = "N";  8'h44: letter = "O";
      8'h4D: letter = "P";  8'h15: letter = "Q";  8'h2D: letter = "R";
      8'h1B: letter = "S";  8'h2C: letter = "T";  8'h3C: letter = "U";
      8'h2A: letter = "V";  8'h1D: letter = "W";  8'h22: letter = "X";
      8'h35: letter = "Y";  8'h1A: letter = "Z";
      8'h45: begin plain = "0";  shifted = ")";  end
      8'h16: begin plain = "1";  shifted = "!";  end
      8'h1E: begin plain = "2";  shifted = "@";  end
      8'h26: begin plain = "3";  shifted = "#";  end
      8'h25: begin plain = "4";  shifted = "$";  end
      8'h2E: begin plain = "5";  shifted = "%";  end
      8'h36: begin plain = "6";  shifted = "^";  end
      8'h3D: begin plain = "7";  shifted = "&";  end
      8'h3E: begin plain = "8";  shifted = "*";  end
      8'h46: begin plain = "9";  shifted = "(";  end
      8'h29: begin plain = " ";  shifted = " ";  end
      8'h5A: begin plain = 8'h0D; shifted = 8'h0D; end
      8'h0E: begin plain = 8'h60; shifted = "~";  end
      8'h4E: begin plain = "-";  shifted = "_";  end
      8'h55: begin plain = "=";  shifted = "+";  end
      8'h54: begin plain = "[";  shifted = "{";  end
      8'h5B: begin plain = "]";  shifted = "}";  end
      8'h5D: begin plain = "\\"; shifted = "|";  end
      8'h4C: begin plain = ";";  shifted = ":";  end
      8'h52: begin plain = "'";  shifted = "\""; end
      8'h41: begin plain = ",";  shifted = "<";  end
      8'h49: begin plain = ".";  shifted = ">";  end
      8'h4A: begin plain = "/";  shifted = "?";  end
      default: ;
    endcase
  end

  // Lower case is the upper-case code with bit 5 set
  assign ascii = (letter != 8'h00) ? (upper ? letter : (letter | 8'h20))
                                   : (shift ? shifted : plain);

endmodule

// File: rtl/ps2_key_event.sv
// Decodes a PS/2 set-2 byte stream into key events, modifier state and press count.
// Latency: evt_valid/err pulse one cycle after the final byte's byte_valid.
// Backpressure: none; every byte_valid strobe is consumed in the cycle it arrives.
// Ports: clk/rst (sync, active-high); byte_valid/byte_data in; evt_* event
//        fields held between events; err pulse; shift/ctrl/caps state; held_*
//        tracks the last non-modifier key pressed; press_count counts new presses.
//        evt_ascii exists only when PS2_KEY_ASCII_EN is defined.
module ps2_key_event
  import ps2_kbd_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int PAUSE_SKIP  = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             evt_valid,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic             evt_repeat,
  output logic             err,
  output logic             shift_held,
  output logic             ctrl_held,
  output logic             caps_lock,
  output logic             held_valid,
  output logic [8:0]       held_code,
  output logic [CNT_W-1:0] press_count
`ifdef PS2_KEY_ASCII_EN
  ,
  output logic [7:0]       evt_ascii
`endif
);

  localparam int TMO_W  = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam int SKIP_W = (PAUSE_SKIP < 2) ? 1 : $clog2(PAUSE_SKIP + 1);

  ps2_state_e        state_q, state_d;
  logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              evt_valid_q, evt_valid_d;
  logic [7:0]        evt_code_q, evt_code_d;
  logic              evt_ext_q, evt_ext_d;
  logic              evt_break_q, evt_break_d;
  logic              evt_repeat_q, evt_repeat_d;
  logic              err_q, err_d;
  logic              lshift_q, lshift_d, rshift_q, rshift_d;
  logic              lctrl_q, lctrl_d, rctrl_q, rctrl_d;
  logic              caps_q, caps_d;
  logic              held_valid_q, held_valid_d;
  logic [8:0]        held_code_q, held_code_d;
  logic [CNT_W-1:0]  press_count_q, press_count_d;

  // Decoded completion of a key sequence in this cycle
  logic       fire, fire_ext, fire_brk;
  logic [8:0] key;
  logic       is_mod;

  always_comb begin
    state_d       = state_q;
    skip_cnt_d    = skip_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    evt_valid_d   = 1'b0;
    evt_code_d    = evt_code_q;
    evt_ext_d     = evt_ext_q;
    evt_break_d   = evt_break_q;
    evt_repeat_d  = evt_repeat_q;
    err_d         = 1'b0;
    lshift_d      = lshift_q;
    rshift_d      = rshift_q;
    lctrl_d       = lctrl_q;
    rctrl_d       = rctrl_q;
    caps_d        = caps_q;
    held_valid_d  = held_valid_q;
    held_code_d   = held_code_q;
    press_count_d = press_count_q;
    fire          = 1'b0;
    fire_ext      = 1'b0;
    fire_brk      = 1'b0;

    // A byte always beats a timeout expiring in the same cycle
    if (byte_valid) begin
      tmo_cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (byte_data == SC_E0) begin
            state_d = EXT;
          end else if (byte_data == SC_F0) begin
            state_d = BRK;
          end else if (byte_data == SC_E1) begin
            state_d    = SKIP;
            skip_cnt_d = SKIP_W'(PAUSE_SKIP);
          end else if (!is_ignored(byte_data)) begin
            fire = 1'b1;
          end
        end
        EXT: begin
          state_d = IDLE;
          if (byte_data == SC_F0) begin
            state_d = EXT_BRK;
          end else if (byte_data == SC_E0 || byte_data == SC_E1) begin
            err_d = 1'b1;
          end else begin
            fire     = 1'b1;
            fire_ext = 1'b1;
          end
        end
        BRK, EXT_BRK: begin
          state_d = IDLE;
          if (is_prefix(byte_data)) begin
            err_d = 1'b1;
          end else begin
            fire     = 1'b1;
            fire_brk = 1'b1;
            fire_ext = (state_q == EXT_BRK);
          end
        end
        SKIP: begin
          skip_cnt_d = skip_cnt_q - 1'b1;
          if (skip_cnt_q <= SKIP_W'(1)) begin
            state_d    = IDLE;
            skip_cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (tmo_cnt_q >= TMO_W'(TIMEOUT_CYC - 1)) begin
        err_d      = 1'b1;
        state_d    = IDLE;
        tmo_cnt_d  = '0;
        skip_cnt_d = '0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end

    key    = {fire_ext, byte_data};
    is_mod = (key == {1'b0, SC_LSHIFT}) || (key == {1'b0, SC_RSHIFT}) ||
             (key == {1'b0, SC_CTRL})   || (key == {1'b1, SC_CTRL});

    if (fire) begin
      evt_valid_d  = 1'b1;
      evt_code_d   = byte_data;
      evt_ext_d    = fire_ext;
      evt_break_d  = fire_brk;
      evt_repeat_d = 1'b0;
      if (is_mod) begin
        // Shift/ctrl follow make/break only; typematic repeats are harmless
        if (key == {1'b0, SC_LSHIFT}) lshift_d = !fire_brk;
        if (key == {1'b0, SC_RSHIFT}) rshift_d = !fire_brk;
        if (key == {1'b0, SC_CTRL})   lctrl_d  = !fire_brk;
        if (key == {1'b1, SC_CTRL})   rctrl_d  = !fire_brk;
      end else if (!fire_brk) begin
        if (held_valid_q && key == held_code_q) begin
          evt_repeat_d = 1'b1;
        end else begin
          held_valid_d  = 1'b1;
          held_code_d   = key;
          press_count_d = press_count_q + 1'b1;
          // Caps lock is tracked like a normal key so its repeats can be
          // recognised and ignored for the toggle
          if (key == {1'b0, SC_CAPS}) caps_d = !caps_q;
        end
      end else if (held_valid_q && key == held_code_q) begin
        held_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      skip_cnt_q    <= '0;
      tmo_cnt_q     <= '0;
      evt_valid_q   <= 1'b0;
      evt_code_q    <= '0;
      evt_ext_q     <= 1'b0;
      evt_break_q   <= 1'b0;
      evt_repeat_q  <= 1'b0;
      err_q         <= 1'b0;
      lshift_q      <= 1'b0;
      rshift_q      <= 1'b0;
      lctrl_q       <= 1'b0;
      rctrl_q       <= 1'b0;
      caps_q        <= 1'b0;
      held_valid_q  <= 1'b0;
      held_code_q   <= '0;
      press_count_q <= '0;
    end else begin
      state_q       <= state_d;
      skip_cnt_q    <= skip_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      evt_valid_q   <= evt_valid_d;
      evt_code_q    <= evt_code_d;
      evt_ext_q     <= evt_ext_d;
      evt_break_q   <= evt_break_d;
      evt_repeat_q  <= evt_repeat_d;
      err_q         <= err_d;
      lshift_q      <= lshift_d;
      rshift_q      <= rshift_d;
      lctrl_q       <= lctrl_d;
      rctrl_q       <= rctrl_d;
      caps_q        <= caps_d;
      held_valid_q  <= held_valid_d;
      held_code_q   <= held_code_d;
      press_count_q <= press_count_d;
    end
  end

`ifdef PS2_KEY_ASCII_EN
  logic [7:0] lut_ascii;
  logic [7:0] evt_ascii_q, evt_ascii_d;

  // Registered modifier state is the state before the current event applies
  ps2_ascii_lut u_ascii_lut (
    .code  (byte_data),
    .upper (lshift_q ^ rshift_q ^ (lshift_q & rshift_q) ^ caps_q),
    .shift (lshift_q | rshift_q),
    .ascii (lut_ascii)
  );

  always_comb begin
    evt_ascii_d = evt_ascii_q;
    if (fire) evt_ascii_d = (fire_ext || fire_brk) ? 8'h00 : lut_ascii;
  end

  always_ff @(posedge clk) begin
    if (rst) evt_ascii_q <= '0;
    else     evt_ascii_q <= evt_ascii_d;
  end

  assign evt_ascii = evt_ascii_q;
`endif

  assign evt_valid   = evt_valid_q;
  assign evt_code    = evt_code_q;
  assign evt_ext     = evt_ext_q;
  assign evt_break   = evt_break_q;
  assign evt_repeat  = evt_repeat_q;
  assign err         = err_q;
  assign shift_held  = lshift_q | rshift_q;
  assign ctrl_held   = lctrl_q | rctrl_q;
  assign caps_lock   = caps_q;
  assign held_valid  = held_valid_q;
  assign held_code   = held_code_q;
  assign press_count = press_count_q;

endmodule

// File: doc/ps2_key_event.md
Name: ps2_key_event

Overview:
- Downstream consumer of the PS/2 byte receiver.
- Turns the raw scan-code byte stream (set 2) into discrete key events: make/break, extended flag and typematic-repeat flag.
- Tracks modifier state (shift, ctrl, caps lock) and counts genuine key presses.
- Feeds the keyboard demo top level (7-seg display, counters) in place of ad-hoc data/data_prev comparisons.

Parameters:
- CNT_W, 8, width of press_count.
- TIMEOUT_CYC, 1_000_000, idle clk cycles allowed mid-sequence before the partial sequence is abandoned.
- PAUSE_SKIP, 7, bytes discarded after an E1 prefix.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- byte_valid  in  1  one-cycle strobe, byte_data valid
- byte_data  in  8  received scan-code byte
- evt_valid  out  1  one-cycle event pulse
- evt_code  out  8  base scan code of event
- evt_ext  out  1  event was E0-prefixed
- evt_break  out  1  1=release, 0=press
- evt_repeat  out  1  press is typematic repeat of held key
- err  out  1  one-cycle pulse on protocol error or timeout
- shift_held  out  1  left (12) or right (59) shift down
- ctrl_held  out  1  left (14) or right (E0 14) ctrl down
- caps_lock  out  1  caps toggle state
- held_valid  out  1  a non-modifier key is currently held
- held_code  out  9  {ext, code} of held key
- press_count  out  CNT_W  count of non-repeat press events, wraps
- evt_ascii  out  8  only with PS2_KEY_ASCII_EN

Behaviour:
- Reset: all outputs 0, FSM=IDLE, internal L/R modifier flags 0, timeout and skip counters 0. Reset mid-sequence discards the partial sequence and emits no event.
- FSM states and transitions:
  - IDLE: E0->EXT; F0->BRK; E1->SKIP (skip_cnt=PAUSE_SKIP); AA, FA, EE, FE, 00, FF are ignored with no event; any other byte -> press event, stay in IDLE.
  - EXT: F0->EXT_BRK; E0/E1 -> err, IDLE; other -> ext press event, IDLE.
  - BRK: E0/F0/E1 -> err, IDLE; other -> break event, IDLE.
  - EXT_BRK: E0/F0/E1 -> err, IDLE; other -> ext break event, IDLE.
  - SKIP: each byte decrements skip_cnt; leave for IDLE when the byte that makes it 0 arrives. No events are produced.
- Latency: evt_valid/err rise in the cycle after the final byte's byte_valid. evt_* fields hold their value until the next event.
- Timeout: in any non-IDLE state, the counter runs while byte_valid=0 and clears on each byte. Reaching TIMEOUT_CYC -> err pulse, IDLE. A byte arriving in the same cycle as expiry wins: it is processed and the timeout is discarded.
- Modifiers:
  - Press sets / break clears lshift(12), rshift(59), lctrl(14), rctrl(E0 14).
  - shift_held and ctrl_held are the ORs of the L/R flags.
  - A non-repeat press of 58 toggles caps_lock. Break and repeat do not toggle it.
  - Modifier events still produce evt_valid but never touch held_* or press_count.
- Repeat and held tracking (non-modifier keys):
  - Press with held_valid=1 and {ext,code}==held_code: evt_repeat=1, count unchanged.
  - Otherwise: evt_repeat=0, held_code<={ext,code}, held_valid<=1, press_count+1 (mod 2^CNT_W).
  - Break matching held_code clears held_valid. Break of a different key leaves it unchanged.
- evt_repeat is always 0 on break events.

Optional Feature:
- Macro PS2_KEY_ASCII_EN.
- Defined: evt_ascii is present and registered alongside evt_*. It holds the ASCII of evt_code for non-extended letters, digits, space, enter and basic punctuation. Letter case is upper when shift_held XOR caps_lock; digits/punctuation follow shift only. Value is 00 for unmapped, extended or break events. Shift state used is the state before the current event is applied.
- Undefined: the port and the lookup logic are absent. All other behaviour is identical.

Decomposition:
- Package ps2_kbd_pkg:
  - FSM state enum (IDLE, EXT, BRK, EXT_BRK, SKIP).
  - Localparams SC_E0, SC_E1, SC_F0, SC_LSHIFT, SC_RSHIFT, SC_CTRL, SC_CAPS.
  - Ignored-byte constants.
- Sub-module ps2_ascii_lut (combinational, instantiated only under PS2_KEY_ASCII_EN): inputs code[7:0], upper, shift; output ascii[7:0].

Test Plan:
- 1C, F0 1C -> press evt (code 1C, ext 0, break 0, repeat 0), press_count 0->1, held_code 01C; then break evt, held_valid 0.
- 1C 1C 1C -> three press evts with repeat 0,1,1; press_count ends at 1.
- 12, 1C, F0 1C, F0 12 -> shift_held 1 after first byte, 0 after final byte; press_count unchanged by shift events; with ASCII_EN the 1C press gives evt_ascii 41. Then 58 then 1C -> caps_lock 1, evt_ascii 41; with shift also held -> 61.
- E0 75, E0 F0 75 -> ext press then ext break of 75. E0 14 -> ctrl_held 1.
- E1 14 77 E1 F0 14 F0 77 then 1C -> no evt and no modifier change during the pause sequence; single press evt for 1C.
- F0 then TIMEOUT_CYC idle cycles -> err pulse, FSM IDLE; subsequent 1C -> press (not break). Assert rst between E0 and 75 -> no evt; all outputs 0.
